// File: rtl/cathero_motion_ctrl_pkg.sv
// Shared types and display/sprite constants for the cat hero motion controller.
package cathero_motion_ctrl_pkg;

  // 96x64 OLED
  localparam int unsigned SCREEN_W = 96;
  localparam int unsigned SCREEN_H = 64;

  // Cat hero sprite footprint (columns 0..16, rows 0..13)
  localparam int unsigned SPRITE_W = 17;
  localparam int unsigned SPRITE_H = 14;

  localparam int unsigned POS_W = 8;
  localparam int unsigned VEL_W = 4;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } motion_state_e;

endpackage

// File: rtl/cathero_motion_ctrl_edge_pulse.sv
// Rising-edge detector: compares the input level with a registered copy.
// Ports: clk, rst_n (async active-low), sig (level in), rise_c (1 while sig=1 and last sampled sig=0).
module cathero_motion_ctrl_edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise_c
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/cathero_motion_ctrl.sv
// Per-frame position controller for the cat hero sprite: horizontal walking with
// edge clamping and a GROUND/RISE/FALL jump-and-gravity state machine.
// Ports:
//   clock, rst_n         - clock, async active-low reset
//   frame_tick           - one-cycle pulse per display frame; all motion steps on it
//   btn_left/right/jump  - debounced button levels
//   x_start, y_start     - sprite top-left corner for the renderer
//   facing_left          - direction of the last requested horizontal move
//   airborne             - state is RISE or FALL
//   land_pulse           - one-cycle pulse after the landing frame
module cathero_motion_ctrl
  import cathero_motion_ctrl_pkg::*;
#(
  parameter int unsigned GROUND_Y = SCREEN_H - SPRITE_H,
  parameter int unsigned X_INIT   = 0,
  parameter int unsigned STEP_X   = 1,
  parameter int unsigned JUMP_V   = 6,
  parameter int unsigned V_MAX    = 7
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_jump,
  output logic [POS_W-1:0] x_start,
  output logic [POS_W-1:0] y_start,
  output logic             facing_left,
  output logic             airborne,
  output logic             land_pulse
);

  localparam int unsigned X_MAX = SCREEN_W - SPRITE_W;

  motion_state_e    state_q, state_d;
  logic [POS_W-1:0] x_q, x_d;
  logic [POS_W-1:0] y_q, y_d;
  logic [VEL_W-1:0] vel_q, vel_d;
  logic             jump_req_q, jump_req_d;
  logic             facing_q, facing_d;
  logic             airborne_q, airborne_d;
  logic             land_q, land_d;

  logic             jump_rise_c;
  logic             move_c;
  logic [POS_W:0]   x_sum_c;
  logic [POS_W:0]   y_sub_c;
  logic [POS_W:0]   y_add_c;
  logic [POS_W-1:0] y_rise_c;
  logic [POS_W-1:0] y_fall_c;
  logic [VEL_W-1:0] vel_dec_c;
  logic [VEL_W-1:0] vel_inc_c;
  logic             landing_c;

  cathero_motion_ctrl_edge_pulse u_jump_edge (
    .clk    (clock),
    .rst_n  (rst_n),
    .sig    (btn_jump),
    .rise_c (jump_rise_c)
  );

  // Vertical arithmetic in 9 bits so the upward subtraction cannot wrap.
  always_comb begin
    vel_dec_c = vel_q - VEL_W'(1);
    vel_inc_c = (vel_q >= VEL_W'(V_MAX)) ? VEL_W'(V_MAX) : vel_q + VEL_W'(1);
    y_sub_c   = {1'b0, y_q} - (POS_W+1)'(vel_q);
    y_rise_c  = y_sub_c[POS_W] ? '0 : y_sub_c[POS_W-1:0];
    y_add_c   = {1'b0, y_q} + (POS_W+1)'(vel_inc_c);
    landing_c = (y_add_c >= (POS_W+1)'(GROUND_Y));
    y_fall_c  = landing_c ? POS_W'(GROUND_Y) : y_add_c[POS_W-1:0];
    move_c    = btn_left ^ btn_right;
    x_sum_c   = {1'b0, x_q} + (POS_W+1)'(STEP_X);
  end

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GROUND;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, evaluated only on frame ticks
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      unique case (state_q)
        GROUND:  if (jump_req_q) state_d = RISE;
        RISE:    if (vel_dec_c == '0) state_d = FALL;
        FALL:    if (landing_c) state_d = GROUND;
        default: state_d = GROUND;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    vel_d      = vel_q;
    facing_d   = facing_q;
    airborne_d = airborne_q;
    land_d     = 1'b0;
    jump_req_d = jump_req_q | jump_rise_c;

    if (frame_tick) begin
      if (move_c) begin
        facing_d = btn_left;
        if (btn_left) begin
          x_d = (x_q < POS_W'(STEP_X)) ? '0 : x_q - POS_W'(STEP_X);
        end else begin
          x_d = (x_sum_c > (POS_W+1)'(X_MAX)) ? POS_W'(X_MAX) : x_sum_c[POS_W-1:0];
        end
      end

      unique case (state_q)
        GROUND: begin
          if (jump_req_q) vel_d = VEL_W'(JUMP_V);
          // A request is consumed here; an edge on this same cycle survives to the next tick.
          jump_req_d = jump_rise_c;
        end
        RISE: begin
          y_d        = y_rise_c;
          vel_d      = vel_dec_c;
          jump_req_d = 1'b0;
        end
        FALL: begin
          y_d        = y_fall_c;
          vel_d      = landing_c ? '0 : vel_inc_c;
          land_d     = landing_c;
          jump_req_d = 1'b0;
        end
        default: begin
          jump_req_d = 1'b0;
        end
      endcase

      airborne_d = (state_d != GROUND);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= POS_W'(X_INIT);
      y_q        <= POS_W'(GROUND_Y);
      vel_q      <= '0;
      jump_req_q <= 1'b0;
      facing_q   <= 1'b0;
      airborne_q <= 1'b0;
      land_q     <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      vel_q      <= vel_d;
      jump_req_q <= jump_req_d;
      facing_q   <= facing_d;
      airborne_q <= airborne_d;
      land_q     <= land_d;
    end
  end

  assign x_start     = x_q;
  assign y_start     = y_q;
  assign facing_left = facing_q;
  assign airborne    = airborne_q;
  assign land_pulse  = land_q;

endmodule

// File: tb/tb_cathero_motion_ctrl.sv
// Directed bench for cathero_motion_ctrl with hand-computed trajectories.
module tb_cathero_motion_ctrl;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic [7:0] x_start;
  logic [7:0] y_start;
  logic       facing_left;
  logic       airborne;
  logic       land_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  // y_start after each of the 13 ticks of a full jump from the ground
  int traj [13] = '{50, 44, 39, 35, 32, 30, 29, 30, 32, 35, 39, 44, 50};

  always #5 clock = ~clock;

  cathero_motion_ctrl dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_jump    (btn_jump),
    .x_start     (x_start),
    .y_start     (y_start),
    .facing_left (facing_left),
    .airborne    (airborne),
    .land_pulse  (land_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame tick; returns on the negedge after the tick edge, when outputs show the update.
  task automatic tick();
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic press_jump();
    @(negedge clock);
    btn_jump = 1'b1;
    @(negedge clock);
    btn_jump = 1'b0;
  endtask

  // Ticks through trajectory indices [from, to) checking y, airborne and land_pulse.
  task automatic jump_ticks(input string tag, input int from, input int to);
    for (int i = from; i < to; i++) begin
      tick();
      check_eq($sformatf("%s_y%0d", tag, i), 32'(y_start), 32'(traj[i]));
      check_eq($sformatf("%s_air%0d", tag, i), 32'(airborne), (i != 12) ? 32'd1 : 32'd0);
      check_eq($sformatf("%s_land%0d", tag, i), 32'(land_pulse), (i == 12) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int xm;
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b1;
    btn_jump   = 1'b1;

    // Reset with buttons active: ticks ignored
    repeat (3) tick();
    check_eq("rst_x", 32'(x_start), 32'd0);
    check_eq("rst_y", 32'(y_start), 32'd50);
    check_eq("rst_air", 32'(airborne), 32'd0);
    check_eq("rst_land", 32'(land_pulse), 32'd0);
    check_eq("rst_face", 32'(facing_left), 32'd0);
    btn_right = 1'b0;
    btn_jump  = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    tick();
    check_eq("idle_x", 32'(x_start), 32'd0);
    check_eq("idle_y", 32'(y_start), 32'd50);
    check_eq("idle_air", 32'(airborne), 32'd0);

    // Full jump trajectory
    press_jump();
    jump_ticks("jump", 0, 13);
    @(negedge clock);
    check_eq("jump_land_once", 32'(land_pulse), 32'd0);
    check_eq("jump_air_after", 32'(airborne), 32'd0);
    check_eq("jump_x", 32'(x_start), 32'd0);

    // Right clamp
    btn_right = 1'b1;
    xm = 0;
    for (int i = 0; i < 85; i++) begin
      tick();
      xm = (xm + 1 > 79) ? 79 : xm + 1;
      check_eq($sformatf("right_x%0d", i), 32'(x_start), 32'(xm));
    end
    check_eq("right_x_end", 32'(x_start), 32'd79);
    check_eq("right_face", 32'(facing_left), 32'd0);
    btn_right = 1'b0;

    // Walk left down to x=2, then clamp at 0
    btn_left = 1'b1;
    repeat (77) tick();
    check_eq("left_x2", 32'(x_start), 32'd2);
    tick();
    check_eq("left_x1", 32'(x_start), 32'd1);
    tick();
    check_eq("left_x0", 32'(x_start), 32'd0);
    tick();
    check_eq("left_x0_clamp", 32'(x_start), 32'd0);
    check_eq("left_face", 32'(facing_left), 32'd1);

    // Both buttons: hold position and facing
    btn_right = 1'b1;
    repeat (3) tick();
    check_eq("both_x", 32'(x_start), 32'd0);
    check_eq("both_face", 32'(facing_left), 32'd1);
    btn_left  = 1'b0;
    btn_right = 1'b0;

    // Second jump edge during RISE: trajectory unchanged, no re-jump
    press_jump();
    jump_ticks("rejump", 0, 2);
    press_jump();
    jump_ticks("rejump", 2, 13);
    repeat (3) tick();
    check_eq("rejump_air_after", 32'(airborne), 32'd0);
    check_eq("rejump_y_after", 32'(y_start), 32'd50);

    // Jump held across landing: only one jump
    @(negedge clock);
    btn_jump = 1'b1;
    jump_ticks("held", 0, 13);
    repeat (4) tick();
    check_eq("held_air_after", 32'(airborne), 32'd0);
    check_eq("held_y_after", 32'(y_start), 32'd50);
    btn_jump = 1'b0;
    repeat (2) tick();

    // Edge coinciding with a tick in GROUND launches on the following tick
    @(negedge clock);
    btn_jump   = 1'b1;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    btn_jump   = 1'b0;
    check_eq("same_tick_air", 32'(airborne), 32'd0);
    check_eq("same_tick_y", 32'(y_start), 32'd50);
    jump_ticks("same", 0, 13);

    // Async reset mid-jump at y=35
    btn_right = 1'b1;
    repeat (5) tick();
    btn_right = 1'b0;
    check_eq("pre_rst_x", 32'(x_start), 32'd5);
    press_jump();
    jump_ticks("abort", 0, 4);
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_x", 32'(x_start), 32'd0);
    check_eq("abort_y", 32'(y_start), 32'd50);
    check_eq("abort_air", 32'(airborne), 32'd0);
    check_eq("abort_land", 32'(land_pulse), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("post_rst_land%0d", i), 32'(land_pulse), 32'd0);
      check_eq($sformatf("post_rst_y%0d", i), 32'(y_start), 32'd50);
    end
    check_eq("post_rst_air", 32'(airborne), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
